// File: rtl/decoder38_stream.sv
`default_nettype none
// ============================================================================
//  Module   : decoder38_stream
//  Purpose  : Streaming 3-to-8 one-hot decoder. 3-bit codes arrive over a
//             valid/ready handshake, are buffered in a small circular FIFO,
//             and are replayed as a registered one-hot byte that is held on
//             Out for HOLD_CYCLES clock cycles per code.
//  Ports    : clk        - single rising-edge clock
//             rst_n      - synchronous active-low reset
//             en         - output enable; gates only the start of new words
//             In         - 3-bit code to decode
//             in_valid   - In is valid this cycle
//             in_ready   - block can accept In this cycle
//             Out        - registered one-hot word (zero when idle)
//             out_valid  - Out holds a decoded word
//             fifo_level - number of buffered codes
//  Revision : 1.0 - initial release
// ============================================================================
module decoder38_stream #(
    parameter int DEPTH       = 4,   // FIFO entries, power of 2, >= 2
    parameter int HOLD_CYCLES = 1    // cycles per output word, 1..255
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic [2:0]               In,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [7:0]               Out,
    output logic                     out_valid,
    output logic [$clog2(DEPTH):0]   fifo_level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    localparam logic [LW-1:0] C_DEPTH       = LW'(DEPTH);
    localparam logic [7:0]    C_HOLD_RELOAD = 8'(HOLD_CYCLES - 1);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_DRIVE = 1'b1;

    // ------------------------------------------------------------------------
    // FIFO storage and bookkeeping
    // ------------------------------------------------------------------------
    logic [2:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [LW-1:0] r_level;

    logic          w_push;
    logic          w_pop;
    logic [2:0]    w_head;
    logic          w_have_data;

    // Readiness depends only on registered level and rst_n; at full there is
    // deliberately no pass-through even when a pop happens in the same cycle.
    assign in_ready    = rst_n && (r_level < C_DEPTH);
    assign w_push      = in_valid && in_ready;
    assign w_head      = r_mem[r_rptr];
    assign w_have_data = (r_level != '0) && en;

    // Storage carries no reset; only the pointers and level define contents.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= In;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Output FSM: state register / next-state logic / output logic
    // ------------------------------------------------------------------------
    logic [0:0] r_state;
    logic [0:0] w_state_nxt;
    logic [7:0] r_out;
    logic [7:0] w_out_nxt;
    logic       r_valid;
    logic       w_valid_nxt;
    logic [7:0] r_hold;
    logic [7:0] w_hold_nxt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_out   <= 8'h00;
            r_valid <= 1'b0;
            r_hold  <= 8'd0;
        end else begin
            r_state <= w_state_nxt;
            r_out   <= w_out_nxt;
            r_valid <= w_valid_nxt;
            r_hold  <= w_hold_nxt;
        end
    end

    // A pop in DRIVE happens on the last hold cycle so consecutive words are
    // back-to-back with no zero gap; en only blocks starting a new word.
    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_have_data) begin
                    w_pop       = 1'b1;
                    w_state_nxt = S_DRIVE;
                end
            end
            S_DRIVE: begin
                if (r_hold == 8'd0) begin
                    if (w_have_data) begin
                        w_pop = 1'b1;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_out_nxt   = r_out;
        w_valid_nxt = r_valid;
        w_hold_nxt  = r_hold;
        if (w_pop) begin
            w_out_nxt   = 8'h01 << w_head;
            w_valid_nxt = 1'b1;
            w_hold_nxt  = C_HOLD_RELOAD;
        end else if (r_state == S_DRIVE) begin
            if (r_hold != 8'd0) begin
                w_hold_nxt = r_hold - 8'd1;
            end else begin
                w_out_nxt   = 8'h00;
                w_valid_nxt = 1'b0;
            end
        end
    end

    assign Out        = r_out;
    assign out_valid  = r_valid;
    assign fifo_level = r_level;

endmodule
`default_nettype wire

// File: tb/tb_decoder38_stream.sv
`default_nettype none
// ============================================================================
//  Module   : tb_decoder38_stream
//  Purpose  : Directed self-checking bench for decoder38_stream. Three
//             instances (HOLD_CYCLES = 1, 3, 4; DEPTH = 4) share clock, reset,
//             enable and code input; each has its own in_valid.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_decoder38_stream;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [2:0] code;
    logic       v1, v3, v4;

    logic       rdy1, rdy3, rdy4;
    logic [7:0] out1, out3, out4;
    logic       ov1, ov3, ov4;
    logic [2:0] lvl1, lvl3, lvl4;

    int total;
    int bad;

    decoder38_stream #(.DEPTH(4), .HOLD_CYCLES(1)) u1 (
        .clk(clk), .rst_n(rst_n), .en(en), .In(code), .in_valid(v1),
        .in_ready(rdy1), .Out(out1), .out_valid(ov1), .fifo_level(lvl1));

    decoder38_stream #(.DEPTH(4), .HOLD_CYCLES(3)) u3 (
        .clk(clk), .rst_n(rst_n), .en(en), .In(code), .in_valid(v3),
        .in_ready(rdy3), .Out(out3), .out_valid(ov3), .fifo_level(lvl3));

    decoder38_stream #(.DEPTH(4), .HOLD_CYCLES(4)) u4 (
        .clk(clk), .rst_n(rst_n), .en(en), .In(code), .in_valid(v4),
        .in_ready(rdy4), .Out(out4), .out_valid(ov4), .fifo_level(lvl4));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle past it before sampling/driving.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b1; code = 3'd5; v1 = 1'b1; v3 = 1'b0; v4 = 1'b0;
        step();
        step();
        total++; if (out1 !== 8'h00) begin bad++; $display("FAIL reset_out got=%h want=00", out1); end
        total++; if (ov1 !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", ov1); end
        total++; if (lvl1 !== 3'd0) begin bad++; $display("FAIL reset_level got=%0d want=0", lvl1); end
        total++; if (rdy1 !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b want=0", rdy1); end
        v1 = 1'b0;
        rst_n = 1'b1;
        #1;
        total++; if (rdy1 !== 1'b1) begin bad++; $display("FAIL post_reset_ready got=%b want=1", rdy1); end
        step();
        total++; if (lvl1 !== 3'd0) begin bad++; $display("FAIL post_reset_level got=%0d want=0", lvl1); end
    endtask

    task automatic test_sweep();
        logic [7:0] exp;
        en = 1'b1;
        for (int k = 0; k < 8; k++) begin
            code = 3'(k);
            v1   = 1'b1;
            step();
            if (k > 0) begin
                exp = 8'h01 << (k - 1);
                total++; if (out1 !== exp) begin bad++; $display("FAIL sweep_out k=%0d got=%h want=%h", k, out1, exp); end
                total++; if (ov1 !== 1'b1) begin bad++; $display("FAIL sweep_valid k=%0d got=%b want=1", k, ov1); end
                total++; if (lvl1 !== 3'd1) begin bad++; $display("FAIL sweep_level k=%0d got=%0d want=1", k, lvl1); end
            end else begin
                total++; if (out1 !== 8'h00) begin bad++; $display("FAIL sweep_first got=%h want=00", out1); end
            end
        end
        v1 = 1'b0;
        step();
        total++; if (out1 !== 8'h80) begin bad++; $display("FAIL sweep_last got=%h want=80", out1); end
        step();
        total++; if (out1 !== 8'h00) begin bad++; $display("FAIL sweep_idle_out got=%h want=00", out1); end
        total++; if (ov1 !== 1'b0) begin bad++; $display("FAIL sweep_idle_valid got=%b want=0", ov1); end
        total++; if (lvl1 !== 3'd0) begin bad++; $display("FAIL sweep_idle_level got=%0d want=0", lvl1); end
    endtask

    task automatic test_hold_stretch();
        logic [7:0] exp_seq [6];
        exp_seq = '{8'h04, 8'h04, 8'h40, 8'h40, 8'h40, 8'h00};
        en = 1'b1;
        code = 3'd2; v3 = 1'b1;
        step();
        total++; if (out3 !== 8'h00) begin bad++; $display("FAIL hold_latency got=%h want=00", out3); end
        code = 3'd6;
        step();
        v3 = 1'b0;
        total++; if (out3 !== 8'h04) begin bad++; $display("FAIL hold_first got=%h want=04", out3); end
        for (int i = 0; i < 6; i++) begin
            step();
            total++; if (out3 !== exp_seq[i]) begin bad++; $display("FAIL hold_seq i=%0d got=%h want=%h", i, out3, exp_seq[i]); end
            total++; if (ov3 !== (exp_seq[i] != 8'h00)) begin bad++; $display("FAIL hold_valid i=%0d got=%b", i, ov3); end
        end
    endtask

    task automatic test_full_backpressure();
        logic [2:0] codes [4];
        logic [7:0] exp_out [4];
        logic [2:0] exp_lvl [4];
        codes   = '{3'd1, 3'd3, 3'd5, 3'd7};
        exp_out = '{8'h20, 8'h80, 8'h04, 8'h00};
        exp_lvl = '{3'd2, 3'd1, 3'd0, 3'd0};
        en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            code = codes[i]; v1 = 1'b1;
            step();
        end
        code = 3'd2;
        total++; if (lvl1 !== 3'd4) begin bad++; $display("FAIL full_level got=%0d want=4", lvl1); end
        total++; if (rdy1 !== 1'b0) begin bad++; $display("FAIL full_ready got=%b want=0", rdy1); end
        step();
        step();
        total++; if (lvl1 !== 3'd4) begin bad++; $display("FAIL full_held_level got=%0d want=4", lvl1); end
        total++; if (out1 !== 8'h00) begin bad++; $display("FAIL full_en0_out got=%h want=00", out1); end
        en = 1'b1;
        step();
        total++; if (out1 !== 8'h02) begin bad++; $display("FAIL full_pop1 got=%h want=02", out1); end
        total++; if (lvl1 !== 3'd3) begin bad++; $display("FAIL full_pop1_level got=%0d want=3", lvl1); end
        total++; if (rdy1 !== 1'b1) begin bad++; $display("FAIL full_pop1_ready got=%b want=1", rdy1); end
        step();
        v1 = 1'b0;
        total++; if (out1 !== 8'h08) begin bad++; $display("FAIL full_pop2 got=%h want=08", out1); end
        total++; if (lvl1 !== 3'd3) begin bad++; $display("FAIL full_pushpop_level got=%0d want=3", lvl1); end
        for (int i = 0; i < 4; i++) begin
            step();
            total++; if (out1 !== exp_out[i]) begin bad++; $display("FAIL full_seq i=%0d got=%h want=%h", i, out1, exp_out[i]); end
            total++; if (lvl1 !== exp_lvl[i]) begin bad++; $display("FAIL full_seq_level i=%0d got=%0d want=%0d", i, lvl1, exp_lvl[i]); end
        end
    endtask

    task automatic test_en_gating();
        logic [7:0] exp_tail [5];
        exp_tail = '{8'h02, 8'h02, 8'h02, 8'h02, 8'h00};
        en = 1'b1;
        code = 3'd4; v4 = 1'b1;
        step();
        code = 3'd1;
        step();
        v4 = 1'b0;
        total++; if (out4 !== 8'h10) begin bad++; $display("FAIL gate_c1 got=%h want=10", out4); end
        step();
        total++; if (out4 !== 8'h10) begin bad++; $display("FAIL gate_c2 got=%h want=10", out4); end
        en = 1'b0;
        step();
        total++; if (out4 !== 8'h10) begin bad++; $display("FAIL gate_c3 got=%h want=10", out4); end
        step();
        total++; if (out4 !== 8'h10) begin bad++; $display("FAIL gate_c4 got=%h want=10", out4); end
        step();
        total++; if (out4 !== 8'h00) begin bad++; $display("FAIL gate_gap got=%h want=00", out4); end
        total++; if (ov4 !== 1'b0) begin bad++; $display("FAIL gate_gap_valid got=%b want=0", ov4); end
        total++; if (lvl4 !== 3'd1) begin bad++; $display("FAIL gate_gap_level got=%0d want=1", lvl4); end
        step();
        total++; if (out4 !== 8'h00) begin bad++; $display("FAIL gate_wait got=%h want=00", out4); end
        en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            total++; if (out4 !== exp_tail[i]) begin bad++; $display("FAIL gate_tail i=%0d got=%h want=%h", i, out4, exp_tail[i]); end
        end
        total++; if (lvl4 !== 3'd0) begin bad++; $display("FAIL gate_end_level got=%0d want=0", lvl4); end
    endtask

    task automatic test_reset_mid();
        logic [2:0] codes [4];
        codes = '{3'd7, 3'd1, 3'd2, 3'd3};
        en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            code = codes[i]; v1 = 1'b1;
            step();
        end
        v1 = 1'b0;
        en = 1'b1;
        step();
        total++; if (out1 !== 8'h80) begin bad++; $display("FAIL mid_pre_out got=%h want=80", out1); end
        total++; if (lvl1 !== 3'd3) begin bad++; $display("FAIL mid_pre_level got=%0d want=3", lvl1); end
        rst_n = 1'b0;
        step();
        total++; if (out1 !== 8'h00) begin bad++; $display("FAIL mid_rst_out got=%h want=00", out1); end
        total++; if (ov1 !== 1'b0) begin bad++; $display("FAIL mid_rst_valid got=%b want=0", ov1); end
        total++; if (lvl1 !== 3'd0) begin bad++; $display("FAIL mid_rst_level got=%0d want=0", lvl1); end
        total++; if (rdy1 !== 1'b0) begin bad++; $display("FAIL mid_rst_ready got=%b want=0", rdy1); end
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            total++; if (out1 !== 8'h00) begin bad++; $display("FAIL mid_stale i=%0d got=%h want=00", i, out1); end
            total++; if (lvl1 !== 3'd0) begin bad++; $display("FAIL mid_stale_level i=%0d got=%0d want=0", i, lvl1); end
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0; en = 1'b0; code = 3'd0; v1 = 1'b0; v3 = 1'b0; v4 = 1'b0;
        #1;
        test_reset();
        test_sweep();
        test_hold_stretch();
        test_full_backpressure();
        test_en_gating();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/decoder38_stream.md
Name: decoder38_stream

Overview:
Streaming 3-to-8 one-hot decoder: the consumer-side counterpart of the 8:3 encoder. It accepts 3-bit codes over a valid/ready handshake and buffers them in a small FIFO. It replays each code as a registered one-hot byte held for a programmable number of cycles. It sits between code-producing control logic and one-hot select/strobe lines.

Parameters:
DEPTH, 4, FIFO entries; power of 2, minimum 2.
HOLD_CYCLES, 1, cycles each one-hot word is driven on Out; legal range 1..255.

Ports:
clk  input  1  single clock, all logic on rising edge.
rst_n  input  1  synchronous, active-low reset.
en  input  1  output enable; gates the start of new output words only.
In  input  3  code to decode.
in_valid  input  1  In is valid this cycle.
in_ready  output  1  block can accept In this cycle.
Out  output  8  registered one-hot word; Out[k]=1 for code k; all-zero when idle.
out_valid  output  1  Out holds a decoded word.
fifo_level  output  $clog2(DEPTH)+1  number of buffered codes.

Behaviour:
- Reset: one clock, synchronous, active-low (rst_n sampled low at a rising edge).
  - Reset values: Out=8'h00, out_valid=0, fifo_level=0, FSM=IDLE, hold counter=0, FIFO pointers=0.
  - in_ready=0 while rst_n=0.
  - Reset mid-operation discards all buffered codes and any word being driven, with no partial completion.
- Input handshake:
  - in_ready = rst_n && (fifo_level < DEPTH). This is a combinational function of registered state plus rst_n only, with no path from in_valid.
  - A push occurs at a rising edge where in_valid && in_ready. In is then written to the FIFO tail and fifo_level increments.
  - When full, in_ready=0 even if a pop happens in the same cycle; there is no pass-through at full.
  - Push and pop in the same edge leave fifo_level unchanged.
  - in_valid while in_ready=0 is ignored; the producer must hold In.
- FIFO: circular buffer, pointers wrap modulo DEPTH, first-in first-out order preserved. fifo_level never exceeds DEPTH and never underflows.
- Output FSM, 2 states:
  - IDLE: Out=0, out_valid=0. If fifo_level>0 && en at an edge: pop head, Out<=1<<head, out_valid<=1, hold<=HOLD_CYCLES-1, go to DRIVE.
  - DRIVE: Out and out_valid are held.
    - If hold>0: hold decrements.
    - If hold==0 and fifo_level>0 and en: pop the next code and load it in the same edge (back-to-back, no zero gap); stay in DRIVE.
    - If hold==0 otherwise: Out<=0, out_valid<=0, go to IDLE.
  - en=0 never truncates a word already in DRIVE; it only blocks new pops. Input acceptance continues while en=0.
- Latency: a code pushed at edge N into an empty FIFO with FSM in IDLE and en=1 appears on Out after edge N+1. It stays for exactly HOLD_CYCLES cycles.
- Out is always one-hot or zero, never multi-hot.
- Sustained throughput: one code per HOLD_CYCLES cycles.

Test Plan:
- Reset: rst_n=0 for 2 cycles with in_valid=1, In=3'd5 -> Out=8'h00, out_valid=0, fifo_level=0, in_ready=0, nothing accepted. After rst_n=1, in_ready=1.
- Single decode sweep, HOLD_CYCLES=1: push codes 0..7, one per cycle, en=1 -> Out sequence 01,02,04,08,10,20,40,80 on consecutive cycles, each one cycle after its push. out_valid=1 throughout, then Out=00.
- Hold stretch, HOLD_CYCLES=3: push 3'd2 then 3'd6 back-to-back -> Out=8'h04 for 3 cycles, then 8'h40 for 3 cycles with no zero gap, then 00.
- Full/backpressure, DEPTH=4, en=0: push 5 codes (1,3,5,7,2) -> first 4 accepted, fifo_level=4, in_ready=0, 5th held. Raise en -> 02,08,20,80 emitted, then code 2 accepted and emitted as 04, order preserved.
- en gating mid-word, HOLD_CYCLES=4: drop en during the 2nd cycle of word 8'h10 -> 8'h10 completes all 4 cycles, next buffered code waits until en=1.
- Reset mid-stream: with fifo_level=3 and Out=8'h80, assert rst_n=0 for one edge -> all outputs reset next cycle, fifo_level=0, no stale codes emitted after release.
